// File: rtl/strategy1_sched.sv
// strategy1_sched
// Sequencing controller for the 4x16 strategy-1 reduction adder. It accepts
// PE result vectors with valid/ready, drives the adder's shared stage enable,
// shadows the two adder register stages with valid bits, presents a
// valid/ready output stream, and pulses done once a layer's vector count has
// been consumed downstream. The controller never touches the data itself.

module strategy1_sched #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_vec,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_strategy_en,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic             v1;
    logic             v2;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] num_r;

    logic             adv;
    logic             in_fire;
    logic             out_fire;
    logic             start_ok;
    logic             in_last;
    logic             out_last;

    // The pipeline may advance whenever stage 2 is empty or being consumed;
    // the enable also fires with no new input so resident data drains out.
    assign adv           = !v2 || i_out_ready;
    assign o_in_ready    = (state == S_RUN) && adv;
    assign in_fire       = i_in_valid && o_in_ready;
    assign o_strategy_en = adv && (in_fire || v1 || v2);
    assign out_fire      = v2 && i_out_ready;
    assign o_out_valid   = v2;
    assign o_busy        = (state != S_IDLE);
    assign o_done        = (state == S_DONE);

    assign start_ok = (state == S_IDLE) && i_start;
    // num_r >= 1 whenever these compares matter, so num_r - 1 never wraps.
    assign in_last  = (in_cnt == num_r - CNT_ONE);
    assign out_last = (out_cnt == num_r - CNT_ONE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the layer sequencer.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_num_vec == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (in_fire && in_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_fire && out_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Valid bits mirror the adder stages: they only move when the adder's
    // enable moves its registers, and a drain cycle loads an invalid bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (o_strategy_en) begin
            v1 <= in_fire;
            v2 <= v1;
        end
    end

    // Layer bookkeeping: count latched on start, progress counters step on
    // their respective handshakes and clear when a new layer begins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_r   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (start_ok) begin
            num_r   <= i_num_vec;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (in_fire) begin
                in_cnt <= in_cnt + CNT_ONE;
            end
            if (out_fire) begin
                out_cnt <= out_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_strategy1_sched.sv
// tb_strategy1_sched
// Self-checking bench for strategy1_sched. A reference model tracks the
// layer phase, the vector ids resident in the two adder stages (-1 for a
// bubble) and the number of vectors moved, and is compared every cycle.

module tb_strategy1_sched;

    localparam int CNT_W = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_start;
    logic [CNT_W-1:0] i_num_vec;
    logic             i_in_valid;
    logic             o_in_ready;
    logic             o_strategy_en;
    logic             o_out_valid;
    logic             i_out_ready;
    logic             o_busy;
    logic             o_done;

    int checks;
    int errors;

    // reference model state
    int m_ph;
    int m_num;
    int m_nin;
    int m_nout;
    int m_stage1;
    int m_stage2;

    // per-layer observations from the DUT
    int cyc;
    int done_cyc;
    int done_cnt;
    int dut_outs;
    int en_cnt;

    strategy1_sched #(.CNT_W(CNT_W)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_num_vec     (i_num_vec),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .o_strategy_en (o_strategy_en),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph     = PH_IDLE;
        m_num    = 0;
        m_nin    = 0;
        m_nout   = 0;
        m_stage1 = -1;
        m_stage2 = -1;
    endtask

    // One clock cycle: apply inputs, compare mid-cycle, then advance the
    // model at the rising edge.
    task automatic step(input bit st, input int nv, input bit iv, input bit ordy);
        bit exp_rdy;
        bit exp_en;
        bit in_take;
        bit out_take;
        bit slot_free;
        i_start     = st;
        i_num_vec   = nv[CNT_W-1:0];
        i_in_valid  = iv;
        i_out_ready = ordy;
        @(negedge i_clk);
        // A vector may enter only while inputs are still owed and the
        // output slot is empty or being emptied this cycle.
        slot_free = (m_stage2 < 0) || ordy;
        exp_rdy   = (m_ph == PH_RUN) && slot_free;
        in_take   = iv && exp_rdy;
        out_take  = (m_stage2 >= 0) && ordy;
        exp_en    = slot_free && (in_take || m_stage1 >= 0 || m_stage2 >= 0);

        check("in_ready",  int'(o_in_ready),    int'(exp_rdy));
        check("en",        int'(o_strategy_en), int'(exp_en));
        check("out_valid", int'(o_out_valid),   int'(m_stage2 >= 0));
        check("busy",      int'(o_busy),        int'(m_ph != PH_IDLE));
        check("done",      int'(o_done),        int'(m_ph == PH_DONE));

        if (o_done) begin
            done_cyc = cyc;
            done_cnt++;
        end
        if (o_out_valid && i_out_ready) dut_outs++;
        if (o_strategy_en) en_cnt++;

        @(posedge i_clk);
        // vectors leave in the order they entered
        if (out_take) begin
            check("out_order", m_stage2, m_nout);
            m_nout++;
        end
        if (exp_en) begin
            m_stage2 = m_stage1;
            m_stage1 = in_take ? m_nin : -1;
        end
        if (in_take) m_nin++;
        case (m_ph)
            PH_IDLE: if (st) begin
                m_num  = nv;
                m_nin  = 0;
                m_nout = 0;
                m_ph   = (nv == 0) ? PH_DONE : PH_RUN;
            end
            PH_RUN:   if (m_nin == m_num) m_ph = PH_DRAIN;
            PH_DRAIN: if (m_nout == m_num) m_ph = PH_DONE;
            default:  m_ph = PH_IDLE;
        endcase
        cyc++;
        #1;
    endtask

    // mode 0: random valid/ready and stray starts
    // mode 1: streaming, with a start re-pulse at cycle 9
    // mode 2: streaming input, output stalled in cycles 4..7
    // mode 3: input toggling 1,0,1,0,1 from cycle 1
    task automatic run_layer(input string name, input int num, input int mode,
                             input int exp_done);
        bit st;
        bit iv;
        bit ordy;
        int budget;
        cyc      = 0;
        done_cyc = -1;
        done_cnt = 0;
        dut_outs = 0;
        en_cnt   = 0;
        budget   = 0;
        step(1'b1, num, 1'b0, 1'b1);
        while (m_ph != PH_IDLE && budget < 4000) begin
            case (mode)
                1: begin st = (cyc == 9); iv = 1'b1; ordy = 1'b1; end
                2: begin st = 1'b0; iv = 1'b1; ordy = !(cyc >= 4 && cyc <= 7); end
                3: begin st = 1'b0; iv = (cyc >= 1 && cyc <= 5 && cyc % 2 == 1); ordy = 1'b1; end
                default: begin
                    st   = ($urandom_range(0, 7) == 0);
                    iv   = ($urandom_range(0, 3) != 0);
                    ordy = ($urandom_range(0, 3) != 0);
                end
            endcase
            step(st, $urandom_range(0, 50), iv, ordy);
            budget++;
        end
        check({name, "_timeout"}, int'(budget < 4000), 1);
        check({name, "_outs"},    dut_outs, num);
        check({name, "_donecnt"}, done_cnt, 1);
        if (exp_done >= 0) check({name, "_donecyc"}, done_cyc, exp_done);
        if (num == 0) check({name, "_en_never"}, en_cnt, 0);
        // idle cycle after the layer
        step(1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        done_cyc    = -1;
        done_cnt    = 0;
        dut_outs    = 0;
        en_cnt      = 0;
        i_start     = 1'b0;
        i_num_vec   = '0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        i_rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_in_ready", int'(o_in_ready),    0);
        check("rst_en",       int'(o_strategy_en), 0);
        check("rst_out_valid",int'(o_out_valid),   0);
        check("rst_busy",     int'(o_busy),        0);
        check("rst_done",     int'(o_done),        0);
        i_rst_n = 1'b1;
        step(1'b0, 0, 1'b0, 1'b1);

        // Mid-RUN reset with both stages full.
        cyc = 0;
        step(1'b1, 4, 1'b0, 1'b1);
        step(1'b0, 4, 1'b1, 1'b1);
        step(1'b0, 4, 1'b1, 1'b1);
        check("pre_rst_out_valid", int'(o_out_valid), 1);
        check("pre_rst_busy",      int'(o_busy),      1);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  int'(o_in_ready),    0);
        check("mid_rst_en",        int'(o_strategy_en), 0);
        check("mid_rst_out_valid", int'(o_out_valid),   0);
        check("mid_rst_busy",      int'(o_busy),        0);
        check("mid_rst_done",      int'(o_done),        0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step(1'b0, 0, 1'b0, 1'b1);

        run_layer("single",   1, 1, 4);
        run_layer("stream",   8, 1, 11);
        run_layer("bp",       4, 2, 11);
        run_layer("bubble",   3, 3, 8);
        run_layer("zero",     0, 1, 1);
        for (int i = 0; i < 12; i++) begin
            run_layer("rand", $urandom_range(1, 40), 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
